quadencoderz3: RTL
==================

// Module: quadencoderz3
// PURPOSE
//  Next-generation quadrature encoder counter with A/B/Z input synchronisers and glitch filters.
//  Provides index-armed zeroing (LinuxCNC index-enable semantics) and a per-index position latch.
//  Keeps a direction-correct signed revolution counter and a sticky illegal-transition error.
//  Sits between the encoder pins and the plugin register interface, one instance per axis.
// PARAMETERS
//  BITS       32  width of the internal count, position and index_position
//  QUAD_TYPE  0   arithmetic right shift applied to position: 0=x4, 1=x2, 2=x1
//  FILTER     3   consecutive stable cycles required before a filtered input changes; 0=bypass, max 255
//  REV_BITS   16  width of the signed revs counter
// PORTS
//  clk             in   1         system clock, all logic on rising edge
//  rst_n           in   1         synchronous reset, active low
//  a, b, z         in   1 each    raw encoder inputs, asynchronous to clk
//  index_enable    in   1         host arms index zeroing while high
//  err_clr         in   1         single-cycle clear for the sticky error flag
//  index_out       out  1         high while armed and waiting for index; drops when the index is taken
//  raw_a/raw_b/raw_z out 1 each   synchroniser outputs, for diagnostics
//  position        out  BITS      signed count >>> QUAD_TYPE
//  index_position  out  BITS      signed raw count latched at the last Z rising edge
//  revs            out  REV_BITS  signed revolution count
//  error           out  1         sticky illegal-transition flag
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - count, revs, index_position, error, index_out, synchronisers, filters and last_dir all go to 0.
//   - FSM goes to IDLE. Reset wins over every other event in the same cycle.
//  Input path, per input:
//   - 2-flop synchroniser (raw_*), then the filter.
//   - Filter: the output takes the synchronised value only after it differs from the output for FILTER consecutive cycles.
//   - Filter latency from pin to filtered value is 2+FILTER cycles; any shorter pulse is dropped.
//  Decode: compares filtered A/B (fa, fb) with the previous-cycle values (pa, pb).
//   - Step: exactly one of fa or fb changed. Direction up = fa ^ pb.
//   - count +/-1, wrapping modulo 2^BITS. last_dir <= direction.
//   - Both changed in the same cycle: illegal. count is unchanged and error <= 1.
//   - error stays set until err_clr=1. If an illegal transition and err_clr occur together, set wins.
//  Index edge: filtered Z rose this cycle (zr = fz & ~pz).
//   - index_position <= count as it stood before this cycle's update.
//   - revs <= revs + 1 if last_dir=up, else revs - 1. Wraps modulo 2^REV_BITS.
//  Index FSM (index_out is registered and equals 1 only in ARMED):
//   - IDLE:  index_enable=1 -> ARMED; index_out goes to 1 on the next edge.
//   - ARMED: zr=1 -> count <= 0 (overrides a same-cycle step), index_out <= 0, go to DONE.
//            index_enable=0 before zr -> IDLE with index_out <= 0; count is untouched.
//   - DONE:  held until index_enable=0, then -> IDLE. A new arm needs index_enable low then high again.
//  Position: position = count >>> QUAD_TYPE; combinational from the count register.
//   - Sign is preserved: a count of -1 with QUAD_TYPE=2 reads as -1.
//  Latency: pin edge to the count update is 2+FILTER+1 cycles.
// TESTING (FILTER=3, BITS=32 unless stated)
//  1. Release reset, drive 8 forward x4 steps, 16 cycles apart.
//     -> count=8, position=8 (QUAD_TYPE=0); position=2 when QUAD_TYPE=2.
//  2. Drive 3 reverse steps from 0.
//     -> count=-3, position=-3; with QUAD_TYPE=1, position=-2 (arithmetic shift).
//  3. Apply a 2-cycle glitch on a. -> count unchanged, error=0.
//     Toggle a and b on the same clk. -> error=1, count unchanged.
//     Pulse err_clr. -> error=0.
//  4. Set count=100, index_enable=1. -> index_out=1 after 1 cycle.
//     Then a Z rise -> count=0, index_position=100, index_out=0.
//     A second Z rise while index_enable is still 1 -> count not re-zeroed.
//  5. Arm, then drop index_enable before Z. -> index_out=0, count unchanged.
//     A Z rise afterwards -> index_position latched, count not zeroed.
//  6. Forward steps plus 3 Z rises -> revs=3. Then reverse steps plus 4 Z rises -> revs=-1.
//     Also: with REV_BITS=4, revs wraps 7 -> -8.
//     Also: assert rst_n=0 mid-sequence -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/quadencoderz3.sv
// Quadrature encoder counter with synchronised, glitch-filtered A/B/Z inputs,
// index-armed zeroing, index position latch, revolution counter and sticky error.

module quadencoderz3_input #(
   parameter int unsigned FILTER = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic raw,
   output logic filt
);
   localparam int unsigned RUN_W = 8;

   logic meta;

   // Two-flop synchroniser for an input asynchronous to clk
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b0;
         raw  <= 1'b0;
      end else begin
         meta <= pin;
         raw  <= meta;
      end
   end

   generate
      if (FILTER == 0) begin : g_bypass
         assign filt = raw;
      end else begin : g_filter
         logic [RUN_W-1:0] run;
         logic             filt_q;

         // Output follows raw only after FILTER consecutive differing cycles
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               run    <= '0;
               filt_q <= 1'b0;
            end else if (raw != filt_q) begin
               if (run == RUN_W'(FILTER - 1)) begin
                  filt_q <= raw;
                  run    <= '0;
               end else begin
                  run <= run + RUN_W'(1);
               end
            end else begin
               run <= '0;
            end
         end

         assign filt = filt_q;
      end
   endgenerate
endmodule

module quadencoderz3 #(
   parameter int unsigned BITS      = 32,
   parameter int unsigned QUAD_TYPE = 0,
   parameter int unsigned FILTER    = 3,
   parameter int unsigned REV_BITS  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       a,
   input  logic                       b,
   input  logic                       z,
   input  logic                       index_enable,
   input  logic                       err_clr,
   output logic                       index_out,
   output logic                       raw_a,
   output logic                       raw_b,
   output logic                       raw_z,
   output logic signed [BITS-1:0]     position,
   output logic signed [BITS-1:0]     index_position,
   output logic signed [REV_BITS-1:0] revs,
   output logic                       error
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                 state;
   logic                   fa, fb, fz;
   logic                   pa, pb, pz;
   logic                   last_dir;
   logic signed [BITS-1:0] count;

   logic a_chg_c, b_chg_c, step_c, illegal_c, up_c, zr_c, take_index_c;

   quadencoderz3_input #(.FILTER(FILTER)) u_in_a (
      .clk(clk), .rst_n(rst_n), .pin(a), .raw(raw_a), .filt(fa)
   );
   quadencoderz3_input #(.FILTER(FILTER)) u_in_b (
      .clk(clk), .rst_n(rst_n), .pin(b), .raw(raw_b), .filt(fb)
   );
   quadencoderz3_input #(.FILTER(FILTER)) u_in_z (
      .clk(clk), .rst_n(rst_n), .pin(z), .raw(raw_z), .filt(fz)
   );

   // Edge detection against the previous filtered values
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pa <= 1'b0;
         pb <= 1'b0;
         pz <= 1'b0;
      end else begin
         pa <= fa;
         pb <= fb;
         pz <= fz;
      end
   end

   always_comb begin
      a_chg_c      = fa ^ pa;
      b_chg_c      = fb ^ pb;
      step_c       = a_chg_c ^ b_chg_c;
      illegal_c    = a_chg_c & b_chg_c;
      up_c         = fa ^ pb;
      zr_c         = fz & ~pz;
      take_index_c = (state == S_ARMED) && zr_c;
   end

   // Index arming: index_out is high only while ARMED
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         index_out <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (index_enable) begin
                  state     <= S_ARMED;
                  index_out <= 1'b1;
               end
            end
            S_ARMED: begin
               if (zr_c) begin
                  state     <= S_DONE;
                  index_out <= 1'b0;
               end else if (!index_enable) begin
                  state     <= S_IDLE;
                  index_out <= 1'b0;
               end
            end
            S_DONE: begin
               if (!index_enable) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               index_out <= 1'b0;
            end
         endcase
      end
   end

   // Position count; a taken index overrides a same-cycle step
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count    <= '0;
         last_dir <= 1'b0;
      end else begin
         if (step_c) begin
            last_dir <= up_c;
         end
         if (take_index_c) begin
            count <= '0;
         end else if (step_c) begin
            count <= up_c ? count + BITS'(1) : count - BITS'(1);
         end
      end
   end

   // Index latch and revolution count use the pre-update count and direction
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         index_position <= '0;
         revs           <= '0;
      end else if (zr_c) begin
         index_position <= count;
         revs           <= last_dir ? revs + REV_BITS'(1) : revs - REV_BITS'(1);
      end
   end

   // Sticky error; a new illegal transition beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         error <= 1'b0;
      end else if (illegal_c) begin
         error <= 1'b1;
      end else if (err_clr) begin
         error <= 1'b0;
      end
   end

   assign position = count >>> QUAD_TYPE;
endmodule
